// File: rtl/led_pattern_gen_if.sv
// Run-time control and display outputs of the LED pattern generator.
// The controller (board logic or a bench) drives mode/speed/pause and observes leds/step.
interface led_pattern_gen_if #(
   parameter int unsigned NUM_LEDS = 8
);
   logic [2:0]          mode;
   logic [1:0]          speed;
   logic                pause;
   logic [NUM_LEDS-1:0] leds;
   logic                step;

   modport master (
      output mode, speed, pause,
      input  leds, step
   );

   modport slave (
      input  mode, speed, pause,
      output leds, step
   );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: a prescaler sets the step rate, and a mode-dependent
// update advances the pattern. A change of mode restarts the pattern from its initial value.
//
// mode | meaning
// -----+------------------------------------------------------------
//  0   | chase-left: single lit LED rotating towards the MSB
//  1   | chase-right: single lit LED rotating towards bit 0
//  2   | bounce: single lit LED walking end to end (dir = UP/DOWN)
//  3   | binary count
//  4   | blink: all on / all off
//  5   | fill bar: fills from bit 0, then clears
//  6,7 | reserved, identical to chase-left
module led_pattern_gen #(
   parameter int unsigned CLK_FREQ = 25_000_000,
   parameter int unsigned NUM_LEDS = 8,
   parameter int unsigned STEP_HZ  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   led_pattern_gen_if.slave bus
);
   localparam int unsigned STEP_TICKS = CLK_FREQ / STEP_HZ;

   typedef enum logic [2:0] {
      M_CHASE_L = 3'd0,
      M_CHASE_R = 3'd1,
      M_BOUNCE  = 3'd2,
      M_BINARY  = 3'd3,
      M_BLINK   = 3'd4,
      M_FILL    = 3'd5,
      M_RSVD6   = 3'd6,
      M_RSVD7   = 3'd7
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   localparam logic [NUM_LEDS-1:0] LEDS_ONE  = NUM_LEDS'(1);
   localparam logic [NUM_LEDS-1:0] LEDS_MSB  = {1'b1, {(NUM_LEDS-1){1'b0}}};
   localparam logic [NUM_LEDS-1:0] LEDS_ONES = '1;

   logic [NUM_LEDS-1:0] leds_q, leds_d;
   logic [31:0]         cnt_q, cnt_d;
   mode_t               mode_q, mode_d;
   dir_t                dir_q, dir_d;
   logic                step_q, step_d;

   mode_t               mode_in;
   logic [31:0]         period_m1;

   assign mode_in   = mode_t'(bus.mode);
   // Rate is re-evaluated every cycle so a speed change lands without clearing the prescaler.
   assign period_m1 = 32'(STEP_TICKS >> bus.speed) - 32'd1;

   function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_t m);
      logic [NUM_LEDS-1:0] p;
      case (m)
         M_CHASE_R: p = LEDS_MSB;
         M_BINARY:  p = '0;
         M_BLINK:   p = LEDS_ONES;
         M_FILL:    p = '0;
         default:   p = LEDS_ONE;
      endcase
      return p;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds_q <= LEDS_ONE;
         cnt_q  <= '0;
         mode_q <= M_CHASE_L;
         dir_q  <= DIR_UP;
         step_q <= 1'b0;
      end else begin
         leds_q <= leds_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
         step_q <= step_d;
      end
   end

   always_comb begin
      leds_d = leds_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      dir_d  = dir_q;
      step_d = 1'b0;

      if (mode_in != mode_q) begin
         mode_d = mode_in;
         cnt_d  = '0;
         dir_d  = DIR_UP;
         leds_d = init_pattern(mode_in);
      end else if (!bus.pause) begin
         if (cnt_q >= period_m1) begin
            cnt_d  = '0;
            step_d = 1'b1;
            case (mode_q)
               M_CHASE_R: leds_d = {leds_q[0], leds_q[NUM_LEDS-1:1]};
               M_BOUNCE: begin
                  if (dir_q == DIR_UP) begin
                     leds_d = leds_q << 1;
                     if (leds_d == LEDS_MSB) dir_d = DIR_DOWN;
                  end else begin
                     leds_d = leds_q >> 1;
                     if (leds_d == LEDS_ONE) dir_d = DIR_UP;
                  end
               end
               M_BINARY:  leds_d = leds_q + LEDS_ONE;
               M_BLINK:   leds_d = ~leds_q;
               M_FILL:    leds_d = (leds_q == LEDS_ONES) ? '0 : ((leds_q << 1) | LEDS_ONE);
               default:   leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
            endcase
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   assign bus.leds = leds_q;
   assign bus.step = step_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with STEP_TICKS = 8, on an 8-LED and a 2-LED instance.
module tb_led_pattern_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   led_pattern_gen_if #(.NUM_LEDS(8)) bus8 ();
   led_pattern_gen_if #(.NUM_LEDS(2)) bus2 ();

   led_pattern_gen #(.CLK_FREQ(16), .NUM_LEDS(8), .STEP_HZ(2)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   led_pattern_gen #(.CLK_FREQ(16), .NUM_LEDS(2), .STEP_HZ(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("mismatch in %s", tag);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [7:0] exp8;
      logic [7:0] bounce_tab [16];
      int         nsteps;

      bounce_tab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

      bus8.mode = 3'd0; bus8.speed = 2'd0; bus8.pause = 1'b0;
      bus2.mode = 3'd1; bus2.speed = 2'd3; bus2.pause = 1'b0;

      // reset state
      cyc(2);
      chk("rst_leds", 32'(bus8.leds), 32'h01);
      chk("rst_step", 32'(bus8.step), 32'h0);
      chk("rst_leds2", 32'(bus2.leds), 32'h1);
      rst_n = 1'b1;

      // 2-LED chase-right: reload to MSB, then rotate
      cyc(1); chk("n2_reload", 32'(bus2.leds), 32'h2);
      cyc(1); chk("n2_step1", 32'(bus2.leds), 32'h1);
      cyc(1); chk("n2_step2", 32'(bus2.leds), 32'h2);

      // chase-left, first step on the 8th edge
      cyc(4);
      chk("first_pre_leds", 32'(bus8.leds), 32'h01);
      chk("first_pre_step", 32'(bus8.step), 32'h0);
      cyc(1);
      chk("first_leds", 32'(bus8.leds), 32'h02);
      chk("first_step", 32'(bus8.step), 32'h1);
      cyc(1);
      chk("step_drop", 32'(bus8.step), 32'h0);
      cyc(7);
      chk("second_leds", 32'(bus8.leds), 32'h04);
      chk("second_step", 32'(bus8.step), 32'h1);
      exp8 = 8'h04;
      for (int i = 0; i < 6; i++) begin
         cyc(8);
         exp8 = {exp8[6:0], exp8[7]};
         chk("chase_left", 32'(bus8.leds), 32'(exp8));
      end
      nsteps = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (bus8.step) nsteps++;
      end
      chk("step_rate", 32'(nsteps), 32'd2);

      // async reset mid-count, no clock edge needed
      cyc(3);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", 32'(bus8.leds), 32'h01);
      chk("async_rst_step", 32'(bus8.step), 32'h0);
      cyc(1);
      rst_n = 1'b1;

      // pause at cnt = 5 for 20 cycles
      cyc(5);
      bus8.pause = 1'b1;
      nsteps = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (bus8.step) nsteps++;
      end
      chk("pause_nostep", 32'(nsteps), 32'd0);
      chk("pause_leds", 32'(bus8.leds), 32'h01);
      bus8.pause = 1'b0;
      cyc(2);
      chk("resume_early", 32'(bus8.step), 32'h0);
      cyc(1);
      chk("resume_step", 32'(bus8.step), 32'h1);
      chk("resume_leds", 32'(bus8.leds), 32'h02);

      // speed 0 -> 3 at cnt = 6
      cyc(6);
      bus8.speed = 2'd3;
      cyc(1);
      chk("spd_step", 32'(bus8.step), 32'h1);
      chk("spd_leds", 32'(bus8.leds), 32'h04);
      cyc(1);
      chk("spd_step2", 32'(bus8.step), 32'h1);
      chk("spd_leds2", 32'(bus8.leds), 32'h08);

      // mode 0 -> 4 mid-count
      bus8.speed = 2'd0;
      cyc(3);
      bus8.mode = 3'd4; bus8.speed = 2'd3;
      cyc(1);
      chk("blink_reload", 32'(bus8.leds), 32'hFF);
      chk("blink_reload_step", 32'(bus8.step), 32'h0);
      cyc(1);
      chk("blink_1", 32'(bus8.leds), 32'h00);
      chk("blink_1_step", 32'(bus8.step), 32'h1);
      cyc(1);
      chk("blink_2", 32'(bus8.leds), 32'hFF);

      // bounce at P = 1
      bus8.mode = 3'd2;
      cyc(1);
      chk("bounce_reload", 32'(bus8.leds), 32'h01);
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         chk("bounce", 32'(bus8.leds), 32'(bounce_tab[i]));
      end

      // binary count across full wrap
      bus8.mode = 3'd3;
      cyc(1);
      chk("bin_reload", 32'(bus8.leds), 32'h00);
      for (int i = 1; i <= 256; i++) begin
         cyc(1);
         chk("binary", 32'(bus8.leds), 32'(i % 256));
      end

      // fill bar
      bus8.mode = 3'd5;
      cyc(1);
      chk("fill_reload", 32'(bus8.leds), 32'h00);
      exp8 = 8'h00;
      for (int i = 0; i < 9; i++) begin
         cyc(1);
         exp8 = (exp8 == 8'hFF) ? 8'h00 : {exp8[6:0], 1'b1};
         chk("fill", 32'(bus8.leds), 32'(exp8));
      end

      // mode 0 -> 6 still reloads, then chases left
      bus8.mode = 3'd0;
      cyc(2);
      chk("m0_step", 32'(bus8.leds), 32'h02);
      bus8.mode = 3'd6;
      cyc(1);
      chk("m6_reload", 32'(bus8.leds), 32'h01);
      chk("m6_reload_step", 32'(bus8.step), 32'h0);
      cyc(1);
      chk("m6_step1", 32'(bus8.leds), 32'h02);
      cyc(1);
      chk("m6_step2", 32'(bus8.leds), 32'h04);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
